// File: rtl/result_drain_if.sv
// Handshake bundle for result_drain: drain request, SRAM read port and output beat stream.
// slave is the drain engine's view; master is the surrounding system's view.
interface result_drain_if #(
  parameter int ADDR_W        = 9,
  parameter int MEM_WORD_SIZE = 64
);
  logic                     start_i;
  logic [ADDR_W-1:0]        start_addr_i;
  logic [ADDR_W-1:0]        end_addr_i;
  logic                     rd_en_o;
  logic [ADDR_W-1:0]        rd_addr_o;
  logic [MEM_WORD_SIZE-1:0] rd_data_i;
  logic                     m_valid_o;
  logic                     m_ready_i;
  logic [MEM_WORD_SIZE-1:0] m_data_o;
  logic                     m_last_o;
  logic                     busy_o;
  logic                     done_o;

  modport slave (
    input  start_i, start_addr_i, end_addr_i, rd_data_i, m_ready_i,
    output rd_en_o, rd_addr_o, m_valid_o, m_data_o, m_last_o, busy_o, done_o
  );

  modport master (
    output start_i, start_addr_i, end_addr_i, rd_data_i, m_ready_i,
    input  rd_en_o, rd_addr_o, m_valid_o, m_data_o, m_last_o, busy_o, done_o
  );
endinterface

// File: rtl/result_drain.sv
// Drains an inclusive, wrapping SRAM address range into a valid/ready beat stream
// through a 2-entry FIFO, issuing reads only when a free slot is guaranteed.
package calculator_pkg;
  parameter int ADDR_W        = 9;
  parameter int MEM_WORD_SIZE = 64;
endpackage

module result_drain
  import calculator_pkg::*;
(
  input  logic          clk_i,
  input  logic          rst_i,
  result_drain_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [ADDR_W-1:0]        addr_p0;
  logic [ADDR_W-1:0]        end_addr;
  logic                     rd_en_p0;
  logic                     last_p0;
  logic                     vld_p1;
  logic                     last_p1;

  logic [MEM_WORD_SIZE-1:0] fifo_data [2];
  logic                     fifo_last [2];
  logic [1:0]               fifo_count;
  logic                     wr_ptr;
  logic                     rd_ptr;
  logic [2:0]               occ;
  logic                     push;
  logic                     pop;
  logic                     head_last;
  logic                     m_valid;
  logic                     done;

  function automatic logic [ADDR_W-1:0] addr_inc(input logic [ADDR_W-1:0] a);
    return a + ADDR_W'(1);
  endfunction

  assign m_valid   = (fifo_count != 2'd0);
  assign head_last = fifo_last[rd_ptr];
  assign pop       = m_valid && bus.m_ready_i;
  assign push      = vld_p1;
  // Slots already owed: buffered words plus the read whose data lands this cycle.
  assign occ       = {1'b0, fifo_count} + {2'b00, vld_p1};

  always_comb begin
    state_nxt = state;
    rd_en_p0  = 1'b0;
    last_p0   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start_i) state_nxt = READ;
      end
      READ: begin
        rd_en_p0 = (occ < 3'd2) || pop;
        last_p0  = rd_en_p0 && (addr_p0 == end_addr);
        if (last_p0) state_nxt = FLUSH;
      end
      FLUSH: begin
        if (pop && head_last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state    <= IDLE;
      addr_p0  <= '0;
      end_addr <= '0;
      done     <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= (state == FLUSH) && pop && head_last;
      if (state == IDLE && bus.start_i) begin
        addr_p0  <= bus.start_addr_i;
        end_addr <= bus.end_addr_i;
      end else if (rd_en_p0) begin
        addr_p0 <= addr_inc(addr_p0);
      end
    end
  end

  // Stage p1: read data returns one cycle after rd_en and is pushed on this edge.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      vld_p1  <= 1'b0;
      last_p1 <= 1'b0;
    end else begin
      vld_p1  <= rd_en_p0;
      last_p1 <= last_p0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 0; i < 2; i++) begin
        fifo_data[i] <= '0;
        fifo_last[i] <= 1'b0;
      end
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      fifo_count <= 2'd0;
    end else begin
      if (push) begin
        fifo_data[wr_ptr] <= bus.rd_data_i;
        fifo_last[wr_ptr] <= last_p1;
        wr_ptr            <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 2'd1;
        2'b01:   fifo_count <= fifo_count - 2'd1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  assign bus.rd_en_o   = rd_en_p0;
  assign bus.rd_addr_o = addr_p0;
  assign bus.m_valid_o = m_valid;
  assign bus.m_data_o  = fifo_data[rd_ptr];
  assign bus.m_last_o  = m_valid && head_last;
  assign bus.busy_o    = (state == READ) || (state == FLUSH);
  assign bus.done_o    = done;

endmodule

// File: tb/tb_result_drain.sv
// Directed bench for result_drain: SRAM model, drain scenarios, stall, wrap, restart and reset.
module tb_result_drain;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  result_drain_if #(.ADDR_W(9), .MEM_WORD_SIZE(64)) bus ();

  result_drain dut (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] word_at(input logic [8:0] a);
    return {16'hD0A7, 7'd0, a, 23'd0, a ^ 9'h155};
  endfunction

  // One-cycle SRAM read latency.
  always @(posedge clk) begin
    if (bus.rd_en_o) bus.rd_data_i <= word_at(bus.rd_addr_o);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_rd_en"}, 64'(bus.rd_en_o), 64'd0);
    check({tag, "_rd_addr"}, 64'(bus.rd_addr_o), 64'd0);
    check({tag, "_m_valid"}, 64'(bus.m_valid_o), 64'd0);
    check({tag, "_m_data"}, bus.m_data_o, 64'd0);
    check({tag, "_m_last"}, 64'(bus.m_last_o), 64'd0);
    check({tag, "_busy"}, 64'(bus.busy_o), 64'd0);
    check({tag, "_done"}, 64'(bus.done_o), 64'd0);
  endtask

  task automatic run_drain(input logic [8:0] sa, input logic [8:0] ea, input int mode,
                           input int restart, output logic [31:0] rd_mask,
                           output logic [31:0] vld_mask, output logic [31:0] done_mask,
                           output logic [63:0] first_beat);
    int          n_words;
    int          n_rd;
    int          n_beat;
    int          n_done;
    logic        prev_stall;
    logic [63:0] prev_data;
    logic        prev_last;
    logic [8:0]  span;
    span       = ea - sa;
    n_words    = int'(span) + 1;
    n_rd       = 0;
    n_beat     = 0;
    n_done     = 0;
    prev_stall = 1'b0;
    prev_data  = '0;
    prev_last  = 1'b0;
    rd_mask    = '0;
    vld_mask   = '0;
    done_mask  = '0;
    first_beat = '0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      bus.start_i      = (cyc == 0) || (restart != 0 && cyc == 2);
      bus.start_addr_i = (cyc == 0) ? sa : 9'h100;
      bus.end_addr_i   = (cyc == 0) ? ea : 9'h1F0;
      bus.m_ready_i    = (mode == 0) ? 1'b1 : ((cyc % 3) == 0);
      #1;
      if (cyc < 32) begin
        rd_mask[cyc]   = bus.rd_en_o;
        vld_mask[cyc]  = bus.m_valid_o;
        done_mask[cyc] = bus.done_o;
      end
      if (cyc == 0) check("busy_before_start", 64'(bus.busy_o), 64'd0);
      if (cyc == 1) check("busy_in_drain", 64'(bus.busy_o), 64'd1);
      check("fifo_count_le2", 64'(dut.fifo_count <= 2'd2), 64'd1);
      if (bus.rd_en_o) begin
        check("rd_addr", 64'(bus.rd_addr_o), 64'(9'(sa + 9'(n_rd))));
        n_rd++;
      end
      if (prev_stall) begin
        check("stall_valid", 64'(bus.m_valid_o), 64'd1);
        check("stall_data", bus.m_data_o, prev_data);
        check("stall_last", 64'(bus.m_last_o), 64'(prev_last));
      end
      if (bus.m_valid_o && bus.m_ready_i) begin
        if (n_beat == 0) first_beat = bus.m_data_o;
        check("beat_data", bus.m_data_o, word_at(9'(sa + 9'(n_beat))));
        check("beat_last", 64'(bus.m_last_o), 64'(n_beat == n_words - 1));
        n_beat++;
      end
      prev_stall = bus.m_valid_o && !bus.m_ready_i;
      prev_data  = bus.m_data_o;
      prev_last  = bus.m_last_o;
      if (bus.done_o) begin
        n_done++;
        break;
      end
    end
    check("n_reads", 64'(n_rd), 64'(n_words));
    check("n_beats", 64'(n_beat), 64'(n_words));
    check("done_seen", 64'(n_done), 64'd1);
    @(negedge clk);
    bus.start_i   = 1'b0;
    bus.m_ready_i = 1'b1;
    #1;
    check("done_one_cycle", 64'(bus.done_o), 64'd0);
    check("busy_after_done", 64'(bus.busy_o), 64'd0);
    check("idle_no_valid", 64'(bus.m_valid_o), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    logic [31:0] rd_mask;
    logic [31:0] vld_mask;
    logic [31:0] done_mask;
    logic [63:0] first_beat;
    int          beats;
    n_checks         = 0;
    n_fail           = 0;
    rst_n            = 1'b0;
    bus.start_i      = 1'b0;
    bus.start_addr_i = '0;
    bus.end_addr_i   = '0;
    bus.m_ready_i    = 1'b1;
    bus.rd_data_i    = '0;

    repeat (3) @(negedge clk);
    #1;
    check_outputs_zero("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Basic four-word drain with exact cycle timing.
    run_drain(9'h010, 9'h013, 0, 0, rd_mask, vld_mask, done_mask, first_beat);
    check("basic_rd_cycles", 64'(rd_mask), 64'h0000_001E);
    check("basic_valid_cycles", 64'(vld_mask), 64'h0000_0078);
    check("basic_done_cycle", 64'(done_mask), 64'h0000_0080);
    check("basic_word_a", first_beat, 64'hD0A7_0010_0000_0145);

    // Single word at the top address.
    run_drain(9'h1FF, 9'h1FF, 0, 0, rd_mask, vld_mask, done_mask, first_beat);
    check("single_rd_cycles", 64'(rd_mask), 64'h0000_0002);
    check("single_word", first_beat, 64'hD0A7_01FF_0000_00AA);

    // Range wrapping through address 0.
    run_drain(9'h1FE, 9'h001, 0, 0, rd_mask, vld_mask, done_mask, first_beat);
    check("wrap_rd_cycles", 64'(rd_mask), 64'h0000_001E);

    // Back-pressure pattern 1,0,0 repeating.
    run_drain(9'h000, 9'h007, 1, 0, rd_mask, vld_mask, done_mask, first_beat);

    // Second start while busy must be ignored.
    run_drain(9'h030, 9'h035, 0, 1, rd_mask, vld_mask, done_mask, first_beat);

    // Reset in the middle of an eight-word drain.
    @(negedge clk);
    bus.start_i      = 1'b1;
    bus.start_addr_i = 9'h000;
    bus.end_addr_i   = 9'h007;
    bus.m_ready_i    = 1'b1;
    beats            = 0;
    for (int cyc = 1; cyc < 50 && beats < 3; cyc++) begin
      @(negedge clk);
      bus.start_i = 1'b0;
      #1;
      if (bus.m_valid_o && bus.m_ready_i) beats++;
    end
    check("beats_before_reset", 64'(beats), 64'd3);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_outputs_zero("mid_reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int cyc = 0; cyc < 6; cyc++) begin
      @(negedge clk);
      #1;
      check("post_reset_valid", 64'(bus.m_valid_o), 64'd0);
      check("post_reset_rd_en", 64'(bus.rd_en_o), 64'd0);
      check("post_reset_busy", 64'(bus.busy_o), 64'd0);
    end
    run_drain(9'h020, 9'h021, 0, 0, rd_mask, vld_mask, done_mask, first_beat);
    check("post_reset_rd_cycles", 64'(rd_mask), 64'h0000_0006);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
